// File: rtl/membus_arbiter_n.sv
// N-channel Membus request arbiter: fixed or round-robin grant, with a grant-ID FIFO
// that routes in-order slave responses back to the channel that issued each request.
module membus_arbiter_n #(
  parameter int N_CH            = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 0,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
  localparam int MASK_W         = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            m_valid,
  output logic [N_CH-1:0]            m_ready,
  input  logic [N_CH*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_CH-1:0]            m_wen,
  input  logic [N_CH*DATA_WIDTH-1:0] m_wdata,
  input  logic [N_CH*MASK_W-1:0]     m_wmask,
  output logic [N_CH-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic                       s_valid,
  input  logic                       s_ready,
  output logic [ADDR_WIDTH-1:0]      s_addr,
  output logic                       s_wen,
  output logic [DATA_WIDTH-1:0]      s_wdata,
  output logic [MASK_W-1:0]          s_wmask,
  input  logic                       s_rvalid,
  input  logic [DATA_WIDTH-1:0]      s_rdata,
  output logic                       err_orphan,
  output logic [CNT_W-1:0]           dbg_count
);

  // Handshake: a request transfers on a cycle where s_valid && s_ready; m_ready[i]
  // mirrors that transfer for the granted channel only, and masters hold until it.
  logic [CH_W-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt;
  logic [CH_W-1:0]  head;
  logic             blocked;
  logic             accept;
  logic             pop;
  logic             found;

  assign blocked   = (count == CNT_W'(MAX_OUTSTANDING));
  assign head      = fifo_mem[rd_ptr];
  assign dbg_count = count;
  assign m_rdata   = s_rdata;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (RR_MODE != 0) begin
      for (int j = 0; j < N_CH; j++) begin
        int idx;
        idx = (int'(rr_ptr) + j) % N_CH;
        if (!found && m_valid[idx]) begin
          gnt   = CH_W'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (m_valid[i]) begin
          gnt   = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // No bypass: a full FIFO blocks requests even when a response pops this cycle.
  always_comb begin
    s_valid  = found && !blocked && !rst;
    accept   = s_valid && s_ready;
    pop      = s_rvalid && (count != '0) && !rst;
    m_ready  = '0;
    m_rvalid = '0;
    s_addr   = '0;
    s_wen    = 1'b0;
    s_wdata  = '0;
    s_wmask  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == CH_W'(i)) begin
        m_ready[i] = accept;
        s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wen      = m_wen[i];
        s_wdata    = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_wmask    = m_wmask[i*MASK_W +: MASK_W];
      end
      if (head == CH_W'(i)) m_rvalid[i] = pop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
        if (RR_MODE != 0)
          rr_ptr <= (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_rvalid && (count == '0)) err_orphan <= 1'b1;
    end
  end

  // Grant-ID storage carries no reset; entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= gnt;
  end

endmodule
